pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//   Parametrised fetch-PC generator for the IF stage; next generation of the plain PC register.
//   Adds a valid/ready handshake to fetch and a priority redirect port from EX.
//   Redirects arriving while rdy_i is low are held pending.
//   Optional direct-mapped BTB with 2-bit counters predicts taken branches at fetch time.
// PARAMETERS
//   ADDR_W      32  PC width in bits
//   RESET_PC    0   first PC presented after reset
//   INSTR_BYTES 4   sequential increment; power of 2
//   BTB_DEPTH   16  BTB entries; power of 2, >=2; IDX_W=log2(BTB_DEPTH)
// PORTS
//   clk               in   1       clock, rising edge
//   rst               in   1       reset, synchronous, active-high
//   rdy_i             in   1       global ready; 0 freezes all state except the pending-redirect latch
//   stall_i           in   1       pipeline stall; same effect as fetch_ready_i=0
//   fetch_ready_i     in   1       IF accepts pc_o this cycle
//   pc_o              out  ADDR_W  current fetch PC
//   pc_valid_o        out  1       pc_o is valid
//   pred_taken_o      out  1       BTB predicts pc_o is a taken branch
//   pred_target_o     out  ADDR_W  predicted target; valid when pred_taken_o=1
//   redirect_valid_i  in   1       EX mispredict/jump redirect
//   redirect_pc_i     in   ADDR_W  redirect target
//   upd_valid_i       in   1       BTB training strobe from EX
//   upd_pc_i          in   ADDR_W  PC of the resolved branch
//   upd_taken_i       in   1       resolved direction
//   upd_target_i      in   ADDR_W  resolved target
// BEHAVIOUR
//   - Reset:
//     - pc_o=RESET_PC, pc_valid_o=0, pred_taken_o=0, pred_target_o=0.
//     - Pending-redirect flag cleared; all BTB valid bits cleared.
//     - pc_valid_o rises in the first cycle after rst deasserts with rdy_i=1.
//   - Acceptance: accept = pc_valid_o & fetch_ready_i & ~stall_i & rdy_i.
//   - Next-PC priority at a clock edge with rdy_i=1:
//     1. Redirect (redirect_valid_i, or the pending flag) -> pc_o=redirect_pc, pc_valid_o=1. Applies even if not accepting; the in-flight PC is dropped.
//     2. Else if accept and pred_taken_o -> pc_o=pred_target_o.
//     3. Else if accept -> pc_o=pc_o+INSTR_BYTES, modulo 2^ADDR_W (wraps, no flag).
//     4. Else hold pc_o and pc_valid_o.
//   - Redirect latency: 1 cycle from redirect_valid_i to the new pc_o.
//   - rdy_i=0:
//     - PC, valid and BTB are frozen.
//     - A redirect is stored in the pending register; the last one wins. It is applied on the first rdy_i=1 edge.
//     - BTB updates are dropped.
//   - Redirect while pending: the live redirect_valid_i value overrides the pending value and clears the flag.
//   - BTB lookup:
//     - Combinational on pc_o.
//     - Index = pc_o[IDX_W+log2(INSTR_BYTES)-1 : log2(INSTR_BYTES)]; tag = the bits of pc_o above the index.
//     - pred_taken_o = pc_valid_o & valid & tag match & ctr[1].
//   - BTB update (on the edge with upd_valid_i & rdy_i):
//     - Hit & taken: ctr=sat_inc(ctr), target=upd_target_i.
//     - Hit & not taken: ctr=sat_dec(ctr).
//     - Miss & taken: allocate/replace the entry with ctr=2'b10.
//     - Miss & not taken: no change.
//     - Counter saturates at 0 and 3.
//   - Same-cycle update and lookup of one entry: the lookup sees the pre-update contents; the update is visible the next cycle.
//   - Reset mid-operation overrides everything, including a redirect or update in the same cycle.
// CONFIGURATION
//   PC_GEN_BTB_EN defined:
//     - BTB storage and lookup as above.
//   PC_GEN_BTB_EN undefined:
//     - No BTB storage; pred_taken_o=0 and pred_target_o=0 constantly.
//     - upd_* inputs are ignored; next PC is always sequential unless redirected.
// TESTING
//   1. Reset with RESET_PC=0, then fetch_ready_i=1 -> pc_o=0,4,8,C on consecutive cycles with pc_valid_o=1.
//   2. Hold stall_i=1 for 3 cycles at pc_o=8 -> pc_o stays 8; after release -> C.
//   3. redirect_valid_i=1 with redirect_pc_i=0x100 while stall_i=1 -> next cycle pc_o=0x100, pc_valid_o=1.
//   4. rdy_i=0 with redirect 0x200 then 0x300 -> pc frozen; at the first rdy_i=1 edge -> pc_o=0x300.
//   5. [BTB] Update pc=0x10 taken target=0x80, then fetch 0x10 -> pred_taken_o=1, next pc_o=0x80.
//      Two not-taken updates -> pred_taken_o=0 and sequential 0x14.
//   6. pc_o=0xFFFFFFFC accepted -> pc_o=0x0 (wrap).
//      [no BTB] Any upd_* -> pred_taken_o stays 0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: fetch handshake, EX redirect and BTB training.
// pc_gen drives the *_o members through the master modport.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              rdy_i;
    logic              stall_i;
    logic              fetch_ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              redirect_valid_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;

    modport master (
        input  rdy_i, stall_i, fetch_ready_i,
        input  redirect_valid_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output pc_o, pc_valid_o, pred_taken_o, pred_target_o
    );

    modport slave (
        output rdy_i, stall_i, fetch_ready_i,
        output redirect_valid_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  pc_o, pc_valid_o, pred_taken_o, pred_target_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator with valid/ready handshake, held redirects and optional BTB.
// Define PC_GEN_BTB_EN to build the direct-mapped BTB with 2-bit counters.
module pc_gen #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                BTB_DEPTH   = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);
    localparam int OFF_W = $clog2(INSTR_BYTES);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              vld_q, vld_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              accept;

    assign accept = vld_q & bus.fetch_ready_i & ~bus.stall_i & bus.rdy_i;

    always_comb begin
        pc_d      = pc_q;
        vld_d     = vld_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (bus.rdy_i) begin
            // A live redirect beats the pending one; either way the latch empties.
            vld_d  = 1'b1;
            pend_d = 1'b0;
            if (bus.redirect_valid_i)    pc_d = bus.redirect_pc_i;
            else if (pend_q)             pc_d = pend_pc_q;
            else if (accept && pred_taken) pc_d = pred_target;
            else if (accept)             pc_d = pc_q + STEP;
        end else if (bus.redirect_valid_i) begin
            pend_d    = 1'b1;
            pend_pc_d = bus.redirect_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            vld_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            vld_q  <= vld_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_pc_q <= pend_pc_d;
    end

`ifdef PC_GEN_BTB_EN
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [BTB_DEPTH-1:0] btb_vld_q;
    logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt_q [BTB_DEPTH];
    logic [1:0]           btb_ctr_q [BTB_DEPTH];
    logic [IDX_W-1:0]     rd_idx, wr_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag;
    logic                 wr_hit, upd_en;
    logic                 unused_bits;

    assign rd_idx = pc_q[IDX_W+OFF_W-1:OFF_W];
    assign rd_tag = pc_q[ADDR_W-1:IDX_W+OFF_W];
    assign wr_idx = bus.upd_pc_i[IDX_W+OFF_W-1:OFF_W];
    assign wr_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+OFF_W];
    assign wr_hit = btb_vld_q[wr_idx] & (btb_tag_q[wr_idx] == wr_tag);
    assign upd_en = bus.upd_valid_i & bus.rdy_i & ~rst;
    assign unused_bits = ^bus.upd_pc_i;

    // Lookup reads registered contents, so a same-cycle update shows up next cycle.
    assign pred_taken  = vld_q & btb_vld_q[rd_idx] & (btb_tag_q[rd_idx] == rd_tag)
                       & btb_ctr_q[rd_idx][1];
    assign pred_target = pred_taken ? btb_tgt_q[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_vld_q <= '0;
        end else if (upd_en && !wr_hit && bus.upd_taken_i) begin
            btb_vld_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (wr_hit) begin
                if (bus.upd_taken_i) begin
                    btb_ctr_q[wr_idx] <= sat_inc(btb_ctr_q[wr_idx]);
                    btb_tgt_q[wr_idx] <= bus.upd_target_i;
                end else begin
                    btb_ctr_q[wr_idx] <= sat_dec(btb_ctr_q[wr_idx]);
                end
            end else if (bus.upd_taken_i) begin
                btb_tag_q[wr_idx] <= wr_tag;
                btb_tgt_q[wr_idx] <= bus.upd_target_i;
                btb_ctr_q[wr_idx] <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_upd  = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_taken_i, bus.upd_target_i};
`endif

    assign bus.pc_o          = pc_q;
    assign bus.pc_valid_o    = vld_q;
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_target;
endmodule
